// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of a bit,
// and restarts from zero on clear or after each full bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (clear || bit_end)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter draining a byte FIFO: 8N1, LSB first, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_e                 state, next_state;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic                      tx_next;
  logic                      bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      parity;
`endif

  // Every state change restarts the bit period so each bit is a full CLKS_PER_BIT.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (next_state != state),
    .bit_end(bit_end)
  );

  always_comb begin
    next_state   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    case (state)
      IDLE:  if (!fifo_empty) next_state = POP;
      POP:   next_state = LOAD;
      LOAD: begin
        shift_next = fifo_data;
        next_state = START;
      end
      START: if (bit_end) next_state = DATA;
      DATA: begin
        if (bit_end) begin
          shift_next   = {1'b0, shift[UART_DATA_BITS-1:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) next_state = STOP;
`endif
      STOP:  if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line level is derived from the upcoming state so tx is a clean flop output.
  always_comb begin
    tx_next = 1'b1;
    case (next_state)
      START: tx_next = 1'b0;
      DATA:  tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = parity;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= next_state;
      shift      <= shift_next;
      bit_idx    <= bit_idx_next;
      tx         <= tx_next;
      fifo_rd_en <= (next_state == POP);
      tx_busy    <= (next_state != IDLE);
      tx_done    <= (state == STOP) && bit_end;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      parity <= 1'b0;
    else if (state == LOAD)
      parity <= ^fifo_data;
  end
`endif

endmodule
